// File: rtl/flash_playback_pkg.sv
//============================================================================
// Module : flash_playback_pkg
// Brief  : Shared widths and FSM state encoding for the flash playback path.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package flash_playback_pkg;
    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_OUT_1     = 3'd3,
        ST_OUT_2     = 3'd4
    } state_t;
endpackage

`default_nettype wire

// File: rtl/flash_playback_sequencer_if.sv
//============================================================================
// Module : flash_if
// Brief  : Flash word-read port (request/waitrequest, pipelined readdata).
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

interface flash_if #(
    parameter int ADDR_W = 23
) ();
    import flash_playback_pkg::*;

    logic              flash_read;
    logic [ADDR_W-1:0] flash_address;
    logic              flash_waitrequest;
    logic [WORD_W-1:0] flash_readdata;
    logic              flash_readdatavalid;

    modport master (
        output flash_read,
        output flash_address,
        input  flash_waitrequest,
        input  flash_readdata,
        input  flash_readdatavalid
    );

    modport slave (
        input  flash_read,
        input  flash_address,
        output flash_waitrequest,
        output flash_readdata,
        output flash_readdatavalid
    );
endinterface

`default_nettype wire

// File: rtl/flash_playback_sequencer_stepper.sv
//============================================================================
// Module : flash_addr_stepper
// Brief  : Playback word-address register with region loads and wrap stepping.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module flash_addr_stepper #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = 'h7FFFF
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              load_start,
    input  wire logic              load_end,
    input  wire logic              step_fwd,
    input  wire logic              step_bwd,
    output logic [ADDR_W-1:0]      addr
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr <= START_ADDR;
        end else if (load_start) begin
            addr <= START_ADDR;
        end else if (load_end) begin
            addr <= END_ADDR;
        end else if (step_fwd) begin
            addr <= (addr == END_ADDR) ? START_ADDR : addr + 1'b1;
        end else if (step_bwd) begin
            addr <= (addr == START_ADDR) ? END_ADDR : addr - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/flash_playback_sequencer.sv
//============================================================================
// Module : flash_playback_sequencer
// Brief  : Reads 32-bit flash words and plays them out as two 16-bit samples.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module flash_playback_sequencer
    import flash_playback_pkg::*;
#(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = 'h7FFFF
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    input  wire logic                play_en,
    input  wire logic                direction,
    input  wire logic                restart,
    input  wire logic                sample_tick,
    flash_if.master                  flash,
    output logic [SAMPLE_W-1:0]      audio_sample,
    output logic                     sample_valid,
    output logic                     read_complete
);

    state_t              r_state;
    logic                r_flash_read;
    logic [WORD_W-1:0]   r_word;
    logic                r_dir_w;
    logic                r_restart_pend;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_boundary;
    logic                w_apply_restart;
    logic                w_load_start;
    logic                w_load_end;
    logic                w_step_fwd;
    logic                w_step_bwd;

    assign flash.flash_read    = r_flash_read;
    assign flash.flash_address = w_addr;

    // Word boundary: second sample of the current word leaves this cycle.
    assign w_boundary      = (r_state == ST_OUT_2) && sample_tick;
    assign w_apply_restart = r_restart_pend || restart;

    always_comb begin
        w_load_start = 1'b0;
        w_load_end   = 1'b0;
        w_step_fwd   = 1'b0;
        w_step_bwd   = 1'b0;
        if (r_state == ST_IDLE && restart) begin
            w_load_start = direction;
            w_load_end   = !direction;
        end else if (w_boundary) begin
            if (w_apply_restart) begin
                w_load_start = direction;
                w_load_end   = !direction;
            end else begin
                w_step_fwd   = direction;
                w_step_bwd   = !direction;
            end
        end
    end

    flash_addr_stepper #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_stepper (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_start (w_load_start),
        .load_end   (w_load_end),
        .step_fwd   (w_step_fwd),
        .step_bwd   (w_step_bwd),
        .addr       (w_addr)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_flash_read   <= 1'b0;
            r_word         <= '0;
            r_dir_w        <= 1'b0;
            r_restart_pend <= 1'b0;
            audio_sample   <= '0;
            sample_valid   <= 1'b0;
            read_complete  <= 1'b0;
        end else begin
            sample_valid  <= 1'b0;
            read_complete <= 1'b0;
            // A restart mid-word is deferred so the in-flight word still plays out.
            if (restart && r_state != ST_IDLE)
                r_restart_pend <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_flash_read <= 1'b0;
                    if (restart) begin
                        read_complete <= 1'b1;
                    end else if (play_en) begin
                        r_flash_read <= 1'b1;
                        r_state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!flash.flash_waitrequest) begin
                        r_flash_read <= 1'b0;
                        r_state      <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (flash.flash_readdatavalid) begin
                        r_word  <= flash.flash_readdata;
                        r_dir_w <= direction;
                        r_state <= ST_OUT_1;
                    end
                end
                ST_OUT_1: begin
                    if (sample_tick) begin
                        audio_sample <= r_dir_w ? r_word[15:0] : r_word[31:16];
                        sample_valid <= 1'b1;
                        r_state      <= ST_OUT_2;
                    end
                end
                ST_OUT_2: begin
                    if (sample_tick) begin
                        audio_sample <= r_dir_w ? r_word[31:16] : r_word[15:0];
                        sample_valid <= 1'b1;
                        if (w_apply_restart) begin
                            read_complete  <= 1'b1;
                            r_restart_pend <= 1'b0;
                        end
                        if (play_en) begin
                            r_flash_read <= 1'b1;
                            r_state      <= ST_REQ;
                        end else begin
                            r_state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_flash_read <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_flash_playback_sequencer.sv
//============================================================================
// Module : tb_flash_playback_sequencer
// Brief  : Directed bench: flash responder model, sample/read logs, scenarios.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_flash_playback_sequencer;
    localparam logic [22:0] C_END = 23'h7FFFF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        play_en = 1'b0;
    logic        direction = 1'b1;
    logic        restart = 1'b0;
    logic        sample_tick = 1'b0;
    logic        tick_en = 1'b0;
    logic [15:0] audio_sample;
    logic        sample_valid;
    logic        read_complete;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sample_log[$];
    logic [22:0] addr_log[$];
    int          rc_count = 0;

    flash_if #(.ADDR_W(23)) fi ();

    flash_playback_sequencer #(
        .ADDR_W     (23),
        .START_ADDR (23'h0),
        .END_ADDR   (C_END)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .play_en       (play_en),
        .direction     (direction),
        .restart       (restart),
        .sample_tick   (sample_tick),
        .flash         (fi),
        .audio_sample  (audio_sample),
        .sample_valid  (sample_valid),
        .read_complete (read_complete)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [22:0] a);
        if (a == 23'h0)
            return 32'hBBBB_AAAA;
        return {16'h1000 + a[15:0], 16'h2000 + a[15:0]};
    endfunction

    // Flash model: accepts when read && !waitrequest, returns data 3 edges later.
    logic        acc;
    logic [22:0] acc_addr;
    logic [22:0] rsp_addr = '0;
    int          rsp_dly = 0;
    initial begin
        fi.flash_readdatavalid = 1'b0;
        fi.flash_readdata      = '0;
        fi.flash_waitrequest   = 1'b0;
    end
    always @(posedge clk) begin
        acc      = fi.flash_read && !fi.flash_waitrequest;
        acc_addr = fi.flash_address;
        #1;
        fi.flash_readdatavalid = 1'b0;
        if (rsp_dly == 1) begin
            fi.flash_readdatavalid = 1'b1;
            fi.flash_readdata      = mem_word(rsp_addr);
        end
        if (rsp_dly > 0)
            rsp_dly--;
        if (acc) begin
            rsp_addr = acc_addr;
            rsp_dly  = 2;
            addr_log.push_back(acc_addr);
        end
    end

    int tick_cnt = 0;
    always @(posedge clk) begin
        #1;
        tick_cnt++;
        sample_tick = tick_en && (tick_cnt % 4 == 0);
    end

    always @(negedge clk) begin
        if (sample_valid)
            sample_log.push_back(audio_sample);
        if (read_complete)
            rc_count++;
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        play_en = 1'b0;
        restart = 1'b0;
        fi.flash_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_samples(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sample_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_reads(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (addr_log.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (fi.flash_read !== 1'b0) begin errors++; $display("FAIL reset_read got=%b exp=0", fi.flash_read); end
        checks++; if (fi.flash_address !== 23'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", fi.flash_address); end
        checks++; if (audio_sample !== 16'h0) begin errors++; $display("FAIL reset_sample got=%h exp=0", audio_sample); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
        checks++; if (read_complete !== 1'b0) begin errors++; $display("FAIL reset_rc got=%b exp=0", read_complete); end
        reset_n = 1'b1;
    endtask

    task automatic test_forward();
        int s0, a0;
        bit ok;
        do_reset();
        s0 = sample_log.size(); a0 = addr_log.size();
        direction = 1'b1; tick_en = 1'b1; play_en = 1'b1;
        wait_reads(a0 + 2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fwd_timeout got=%0d reads exp=2", addr_log.size() - a0); end
        play_en = 1'b0;
        if (ok) begin
            checks++; if (addr_log[a0] !== 23'h0) begin errors++; $display("FAIL fwd_addr0 got=%h exp=0", addr_log[a0]); end
            checks++; if (sample_log[s0] !== 16'hAAAA) begin errors++; $display("FAIL fwd_s0 got=%h exp=AAAA", sample_log[s0]); end
            checks++; if (sample_log[s0+1] !== 16'hBBBB) begin errors++; $display("FAIL fwd_s1 got=%h exp=BBBB", sample_log[s0+1]); end
            checks++; if (addr_log[a0+1] !== 23'h1) begin errors++; $display("FAIL fwd_addr1 got=%h exp=1", addr_log[a0+1]); end
        end
    endtask

    task automatic test_backward_wrap();
        int s0, a0;
        bit ok;
        do_reset();
        s0 = sample_log.size(); a0 = addr_log.size();
        direction = 1'b0; play_en = 1'b1;
        wait_reads(a0 + 2, ok);
        direction = 1'b1;
        if (ok) wait_reads(a0 + 3, ok);
        play_en = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL bwd_timeout got=%0d reads exp=3", addr_log.size() - a0); end
        if (ok) begin
            checks++; if (sample_log[s0] !== 16'hBBBB) begin errors++; $display("FAIL bwd_s0 got=%h exp=BBBB", sample_log[s0]); end
            checks++; if (sample_log[s0+1] !== 16'hAAAA) begin errors++; $display("FAIL bwd_s1 got=%h exp=AAAA", sample_log[s0+1]); end
            checks++; if (addr_log[a0+1] !== C_END) begin errors++; $display("FAIL bwd_wrap got=%h exp=7ffff", addr_log[a0+1]); end
            checks++; if (sample_log[s0+2] !== 16'h1FFF) begin errors++; $display("FAIL end_s0 got=%h exp=1FFF", sample_log[s0+2]); end
            checks++; if (sample_log[s0+3] !== 16'h0FFF) begin errors++; $display("FAIL end_s1 got=%h exp=0FFF", sample_log[s0+3]); end
            checks++; if (addr_log[a0+2] !== 23'h0) begin errors++; $display("FAIL fwd_wrap got=%h exp=0", addr_log[a0+2]); end
        end
    endtask

    task automatic test_waitrequest();
        int s0, a0;
        bit ok, stable;
        do_reset();
        s0 = sample_log.size(); a0 = addr_log.size();
        direction = 1'b1; fi.flash_waitrequest = 1'b1; play_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fi.flash_read) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL wr_no_read got=0 exp=1"); end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (fi.flash_read !== 1'b1 || fi.flash_address !== 23'h0) stable = 1'b0;
        end
        checks++; if (!stable) begin errors++; $display("FAIL wr_stable got=0 exp=1"); end
        fi.flash_waitrequest = 1'b0; play_en = 1'b0;
        repeat (60) @(negedge clk);
        checks++; if (addr_log.size() - a0 !== 1) begin errors++; $display("FAIL wr_reads got=%0d exp=1", addr_log.size() - a0); end
        checks++; if (sample_log.size() - s0 !== 2) begin errors++; $display("FAIL wr_samples got=%0d exp=2", sample_log.size() - s0); end
    endtask

    task automatic test_restart();
        int s0, a0, r0;
        bit ok;
        do_reset();
        s0 = sample_log.size(); a0 = addr_log.size(); r0 = rc_count;
        direction = 1'b1; play_en = 1'b1;
        wait_reads(a0 + 11, ok);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        if (ok) wait_reads(a0 + 12, ok);
        play_en = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL rst_timeout got=%0d reads exp=12", addr_log.size() - a0); end
        if (ok) begin
            checks++; if (addr_log[a0+10] !== 23'd10) begin errors++; $display("FAIL rs_addr10 got=%h exp=a", addr_log[a0+10]); end
            checks++; if (sample_log[s0+20] !== 16'h200A) begin errors++; $display("FAIL rs_s0 got=%h exp=200A", sample_log[s0+20]); end
            checks++; if (sample_log[s0+21] !== 16'h100A) begin errors++; $display("FAIL rs_s1 got=%h exp=100A", sample_log[s0+21]); end
            checks++; if (rc_count - r0 !== 1) begin errors++; $display("FAIL rs_complete got=%0d exp=1", rc_count - r0); end
            checks++; if (addr_log[a0+11] !== 23'h0) begin errors++; $display("FAIL rs_next got=%h exp=0", addr_log[a0+11]); end
        end
    endtask

    task automatic test_pause();
        int s0, a0;
        bit ok;
        do_reset();
        s0 = sample_log.size(); a0 = addr_log.size();
        direction = 1'b1; play_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (fi.flash_readdatavalid) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        play_en = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL pause_no_data got=0 exp=1"); end
        repeat (60) @(negedge clk);
        checks++; if (sample_log.size() - s0 !== 2) begin errors++; $display("FAIL pause_samples got=%0d exp=2", sample_log.size() - s0); end
        checks++; if (addr_log.size() - a0 !== 1) begin errors++; $display("FAIL pause_reads got=%0d exp=1", addr_log.size() - a0); end
        checks++; if (fi.flash_read !== 1'b0) begin errors++; $display("FAIL pause_read got=%b exp=0", fi.flash_read); end
        play_en = 1'b1;
        wait_samples(s0 + 4, ok);
        play_en = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL resume_timeout got=%0d exp=4", sample_log.size() - s0); end
        if (ok) begin
            checks++; if (addr_log[a0+1] !== 23'h1) begin errors++; $display("FAIL resume_addr got=%h exp=1", addr_log[a0+1]); end
            checks++; if (sample_log[s0+2] !== 16'h2001) begin errors++; $display("FAIL resume_s0 got=%h exp=2001", sample_log[s0+2]); end
            checks++; if (sample_log[s0+3] !== 16'h1001) begin errors++; $display("FAIL resume_s1 got=%h exp=1001", sample_log[s0+3]); end
        end
    endtask

    task automatic test_reset_midread();
        int s0, a0;
        bit ok;
        do_reset();
        s0 = sample_log.size(); a0 = addr_log.size();
        direction = 1'b1; fi.flash_waitrequest = 1'b1; play_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fi.flash_read) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL mid_no_read got=0 exp=1"); end
        // The flash accepts on the same edge the reset lands, so its data arrives stale.
        reset_n = 1'b0; fi.flash_waitrequest = 1'b0; play_en = 1'b0;
        @(negedge clk);
        checks++; if (fi.flash_read !== 1'b0) begin errors++; $display("FAIL mid_read got=%b exp=0", fi.flash_read); end
        checks++; if (fi.flash_address !== 23'h0) begin errors++; $display("FAIL mid_addr got=%h exp=0", fi.flash_address); end
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (addr_log.size() - a0 !== 1) begin errors++; $display("FAIL mid_accept got=%0d exp=1", addr_log.size() - a0); end
        checks++; if (sample_log.size() - s0 !== 0) begin errors++; $display("FAIL mid_stale got=%0d exp=0", sample_log.size() - s0); end
    endtask

    initial begin
        test_reset();
        tick_en = 1'b1;
        test_forward();
        test_backward_wrap();
        test_waitrequest();
        test_restart();
        test_pause();
        test_reset_midread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=timeout exp=finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
